// File: rtl/fpu_issue_sched.sv
// FPU issue sequencer: accepts one FP op, counts its class latency, and owns
// the FP-regfile / integer writeback handshake. Optional FPU_FAST_ISSUE_EN.
module fpu_issue_sched #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_MADD = 5,
  parameter int LAT_CVT  = 2,
  parameter int LAT_MV   = 1,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [31:0] issue_inst,
  output logic        fpu_busy,
  output logic        fpu_start,
  output logic        res_capture,
  input  logic        fld_wb_en,
  output logic        fp_we,
  output logic [4:0]  fp_wb_rd,
  output logic        int_wb_req,
  output logic [4:0]  int_wb_rd,
  input  logic        int_wb_gnt
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  localparam logic [4:0] OPC_OP_FP   = 5'b10100;
  localparam logic [4:0] OPC_FP_MADD = 5'b10000;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [4:0]       rd_reg, rd_next;
  logic             to_int_reg, to_int_next;

  logic [4:0]       opcode5;
  logic [3:0]       funct4;
  logic [CNT_W-1:0] lat;
  logic             inst_to_int;
  logic             wb_done;
  logic             can_accept;
  logic             accept;
  logic             unused_inst_bits;

  assign opcode5          = issue_inst[6:2];
  assign funct4           = issue_inst[31:28];
  assign unused_inst_bits = ^{issue_inst[27:12], issue_inst[1:0]};
  assign inst_to_int      = (opcode5 == OPC_OP_FP) && (funct4 == 4'b1110);

  always_comb begin
    lat = CNT_W'(LAT_MV);
    if (opcode5 == OPC_FP_MADD) begin
      lat = CNT_W'(LAT_MADD);
    end else begin
      case (funct4)
        4'b0000: lat = CNT_W'(LAT_ADD);
        4'b0001: lat = CNT_W'(LAT_MUL);
        4'b1101: lat = CNT_W'(LAT_CVT);
        default: lat = CNT_W'(LAT_MV);
      endcase
    end
  end

  // Writeback completes when the shared port is free (FP) or the slot is granted (int).
  assign wb_done = (state_reg == WB) && (to_int_reg ? int_wb_gnt : !fld_wb_en);

`ifdef FPU_FAST_ISSUE_EN
  assign can_accept = (state_reg == IDLE) || wb_done;
  assign fpu_busy   = (state_reg != IDLE) && !wb_done;
`else
  assign can_accept = (state_reg == IDLE);
  assign fpu_busy   = (state_reg != IDLE);
`endif

  // Gated by rst_n so every output is 0 while reset is held.
  assign accept = issue_valid && can_accept && rst_n;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rd_next     = rd_reg;
    to_int_next = to_int_reg;
    fpu_start   = 1'b0;
    res_capture = 1'b0;
    fp_we       = 1'b0;
    int_wb_req  = 1'b0;
    case (state_reg)
      EXEC: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          res_capture = 1'b1;
          state_next  = WB;
        end
      end
      WB: begin
        if (to_int_reg) int_wb_req = 1'b1;
        else            fp_we      = !fld_wb_en;
        if (wb_done) state_next = IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      fpu_start   = 1'b1;
      state_next  = EXEC;
      cnt_next    = lat;
      rd_next     = issue_inst[11:7];
      to_int_next = inst_to_int;
    end
  end

  assign fp_wb_rd  = (state_reg != IDLE) ? rd_reg : 5'd0;
  assign int_wb_rd = (state_reg != IDLE) ? rd_reg : 5'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rd_reg     <= '0;
      to_int_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rd_reg     <= rd_next;
      to_int_reg <= to_int_next;
    end
  end

endmodule
